fp_sqrt_iter: RTL and testbench

Parametrised, multi-cycle IEEE-754 floating-point square root unit with valid/ready handshakes on input and output. It is the sequential successor to the combinational single-precision `square_root`. It computes the root mantissa with a one-bit-per-cycle restoring algorithm and rounds round-to-nearest-even. It sits in the TPU vector post-processing path (normalisation/activation stages), where area matters more than throughput.

---
 rtl/fp_sqrt_pkg.sv | 33 +++
 rtl/fp_sqrt_classify.sv | 30 +++
 rtl/fp_sqrt_iter.sv | 179 +++++++++++++++++
 tb/tb_fp_sqrt_iter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the iterative floating-point square root.
package fp_sqrt_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operand classes after flush-to-zero.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Exponent bias for an exponent field of exp_w bits.
    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN (sign 0, exponent all ones, mantissa MSB set),
    // right-aligned in a 64-bit word; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (ones << man_w) | (64'd1 << (man_w - 32'd1));
    endfunction

endpackage

// File: rtl/fp_sqrt_classify.sv
// Combinational unpack of an IEEE-754 word into sign/exponent/mantissa and
// class. Denormals are flushed to a zero of the same sign.
module fp_sqrt_classify
    import fp_sqrt_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] data,
    output logic                 sign,
    output logic [EXP_W-1:0]     expo,
    output logic [MAN_W-1:0]     man,
    output fp_class_t            cls
);

    // Field extraction and classification.
    always_comb begin
        sign = data[EXP_W+MAN_W];
        expo = data[EXP_W+MAN_W-1:MAN_W];
        man  = data[MAN_W-1:0];
        cls  = NORM;
        if (data[EXP_W+MAN_W-1:MAN_W] == '0) begin
            cls = ZERO;
            man = '0;
        end else if (data[EXP_W+MAN_W-1:MAN_W] == '1) begin
            cls = (data[MAN_W-1:0] == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 square root: one root bit per cycle (restoring),
// round-to-nearest-even, valid/ready on both sides, one operation in flight.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid is never withdrawn and data never changes while valid is
// high and ready is low.
module fp_sqrt_iter
    import fp_sqrt_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic                 out_invalid,
    output state_t               dbg_state
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 2;          // root bits: hidden, fraction, guard
    localparam int RW = MAN_W + 4;          // remainder width
    localparam int CW = $clog2(N + 1);
    localparam int BIAS = fp_bias(EXP_W);
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(BIAS);
    localparam logic [63:0] QNAN64 = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QNAN64[W-1:0];

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [N-1:0]     root;
    logic [RW-1:0]    rem;
    logic [N-1:0]     rad;
    logic [EXP_W-1:0] res_exp;

    logic             c_sign;
    logic [EXP_W-1:0] c_exp;
    logic [MAN_W-1:0] c_man;
    fp_class_t        c_cls;

    fp_sqrt_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
        .data (in_data),
        .sign (c_sign),
        .expo (c_exp),
        .man  (c_man),
        .cls  (c_cls)
    );

    logic                    is_norm;
    logic [W-1:0]            spec_data;
    logic                    spec_inv;
    logic signed [EXP_W+1:0] e_unb, e_adj, exp_sum;
    logic [EXP_W-1:0]        res_exp_next;
    logic [N-1:0]            rad_init;

    // Operand setup: special results, halved exponent and aligned radicand.
    always_comb begin
        is_norm   = (c_cls == NORM) && !c_sign;
        spec_data = '0;
        spec_inv  = 1'b0;
        case (c_cls)
            NAN:  spec_data = QNAN;
            ZERO: spec_data = {c_sign, {(W-1){1'b0}}};
            default: begin
                if (c_sign) begin
                    spec_data = QNAN;
                    spec_inv  = 1'b1;
                end else begin
                    spec_data = in_data;
                end
            end
        endcase
        // An odd unbiased exponent moves one factor of two into the radicand.
        e_unb        = $signed({2'b00, c_exp}) - BIAS_S;
        e_adj        = e_unb - $signed({{(EXP_W+1){1'b0}}, e_unb[0]});
        exp_sum      = (e_adj >>> 1) + BIAS_S;
        res_exp_next = exp_sum[EXP_W-1:0];
        rad_init     = e_unb[0] ? {1'b1, c_man, 1'b0} : {2'b01, c_man};
    end

    logic [RW-1:0]    rem_sh, trial, rem_n;
    logic [N-1:0]     root_n;
    logic             ge;

    // One restoring step: bring down two radicand bits, try root*4+1.
    always_comb begin
        rem_sh = {rem[RW-3:0], rad[N-1:N-2]};
        trial  = {root, 2'b01};
        ge     = (rem_sh >= trial);
        rem_n  = ge ? (rem_sh - trial) : rem_sh;
        root_n = {root[N-2:0], ge};
    end

    logic             round_up, carry;
    logic [MAN_W+1:0] mant_sum;
    logic [MAN_W-1:0] final_man;
    logic [EXP_W-1:0] final_exp;

    // Round-to-nearest-even on guard (root[0]), sticky and LSB (root[1]).
    always_comb begin
        round_up  = root[0] & ((rem != '0) | root[1]);
        mant_sum  = {1'b0, root[N-1:1]} + {{(MAN_W+1){1'b0}}, round_up};
        carry     = mant_sum[MAN_W+1];
        final_man = carry ? '0 : mant_sum[MAN_W-1:0];
        final_exp = res_exp + {{(EXP_W-1){1'b0}}, carry};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = is_norm ? ITER : DONE;
            ITER:    if (cnt == '0) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        dbg_state = state;
    end

    // Datapath registers: counter, root/remainder/radicand, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            root        <= '0;
            rem         <= '0;
            rad         <= '0;
            res_exp     <= '0;
            out_data    <= '0;
            out_invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt     <= CW'(N - 1);
                        root    <= '0;
                        rem     <= '0;
                        rad     <= rad_init;
                        res_exp <= res_exp_next;
                        if (!is_norm) begin
                            out_data    <= spec_data;
                            out_invalid <= spec_inv;
                        end
                    end
                end
                ITER: begin
                    rad  <= {rad[N-3:0], 2'b00};
                    rem  <= rem_n;
                    root <= root_n;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                ROUND: begin
                    out_data    <= {1'b0, final_exp, final_man};
                    out_invalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Bench for fp_sqrt_iter: single- and half-precision instances, directed
// vectors, backpressure, mid-operation reset and random normals against an
// arithmetic reference model.
`timescale 1ns/1ps
module tb_fp_sqrt_iter;
    import fp_sqrt_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sp_in_valid = 1'b0, sp_in_ready, sp_out_valid, sp_out_ready = 1'b0, sp_out_invalid;
    logic [31:0] sp_in_data = '0, sp_out_data;
    state_t      sp_dbg;
    logic        hp_in_valid = 1'b0, hp_in_ready, hp_out_valid, hp_out_ready = 1'b0, hp_out_invalid;
    logic [15:0] hp_in_data = '0, hp_out_data;
    state_t      hp_dbg;

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut_sp (
        .clk(clk), .rst(rst),
        .in_valid(sp_in_valid), .in_ready(sp_in_ready), .in_data(sp_in_data),
        .out_valid(sp_out_valid), .out_ready(sp_out_ready), .out_data(sp_out_data),
        .out_invalid(sp_out_invalid), .dbg_state(sp_dbg)
    );

    fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) dut_hp (
        .clk(clk), .rst(rst),
        .in_valid(hp_in_valid), .in_ready(hp_in_ready), .in_data(hp_in_data),
        .out_valid(hp_out_valid), .out_ready(hp_out_ready), .out_data(hp_out_data),
        .out_invalid(hp_out_invalid), .dbg_state(hp_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // {invalid, data}

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: exact integer square root of the scaled significand,
    // rounded to nearest (ties impossible for a square root), plus the
    // IEEE special-case rules.
    function automatic logic [32:0] ref_sqrt(input logic [31:0] a, input int ew, input int mw);
        longint e_field, m_field, e_max, bias, qnan, m, v, r, e, re;
        bit s;
        e_max   = (longint'(1) << ew) - 1;
        bias    = (longint'(1) << (ew - 1)) - 1;
        qnan    = (e_max << mw) | (longint'(1) << (mw - 1));
        s       = a[ew+mw];
        e_field = (longint'(a) >> mw) & e_max;
        m_field = longint'(a) & ((longint'(1) << mw) - 1);
        if (e_field == e_max && m_field != 0) return {1'b0, 32'(qnan)};
        if (e_field == 0) return s ? {1'b0, 32'(longint'(1) << (ew + mw))} : 33'd0;
        if (s) return {1'b1, 32'(qnan)};
        if (e_field == e_max) return {1'b0, a};
        e = e_field - bias;
        m = (longint'(1) << mw) | m_field;
        if (e % 2 != 0) begin
            m = m * 2;
            e = e - 1;
        end
        re = e / 2 + bias;
        v  = m << mw;
        r  = longint'($floor($sqrt(real'(v))));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        if (4 * v > (2 * r + 1) * (2 * r + 1)) r++;
        if (r == (longint'(2) << mw)) begin
            re++;
            r = longint'(1) << mw;
        end
        return {1'b0, 32'((re << mw) | (r - (longint'(1) << mw)))};
    endfunction

    function automatic bit is_pos_normal(input logic [31:0] a, input int ew, input int mw);
        longint e_field;
        e_field = (longint'(a) >> mw) & ((longint'(1) << ew) - 1);
        return !a[ew+mw] && e_field != 0 && e_field != (longint'(1) << ew) - 1;
    endfunction

    function automatic logic [31:0] rand_normal(input int ew, input int mw);
        logic [31:0] e_f, m_f;
        e_f = $urandom_range((1 << ew) - 2, 1);
        m_f = $urandom & ((32'd1 << mw) - 32'd1);
        return (e_f << mw) | m_f;
    endfunction

    // ---------------- driver tasks ----------------
    function automatic bit rdy(input bit hp);
        return hp ? hp_in_ready : sp_in_ready;
    endfunction
    function automatic bit vld(input bit hp);
        return hp ? hp_out_valid : sp_out_valid;
    endfunction
    function automatic logic [32:0] dat(input bit hp);
        return hp ? {hp_out_invalid, 16'h0, hp_out_data} : {sp_out_invalid, sp_out_data};
    endfunction

    task automatic drive(input bit hp, input bit v, input logic [31:0] d);
        if (hp) begin
            hp_in_valid = v;
            hp_in_data  = d[15:0];
        end else begin
            sp_in_valid = v;
            sp_in_data  = d;
        end
    endtask

    task automatic set_ordy(input bit hp, input bit v);
        if (hp) hp_out_ready = v;
        else    sp_out_ready = v;
    endtask

    // One full transaction: accept, measure latency, optional backpressure,
    // output handshake, and return-to-idle check.
    task automatic run_op(input bit hp, input logic [31:0] a, input int hold,
                          input bit use_want, input logic [32:0] want, input string tag);
        int ew, mw, lat, exp_lat;
        logic [32:0] exp_v;
        ew = hp ? 5 : 8;
        mw = hp ? 10 : 23;
        exp_q.push_back(use_want ? want : ref_sqrt(a, ew, mw));
        exp_lat = is_pos_normal(a, ew, mw) ? mw + 4 : 1;
        lat = 0;
        @(negedge clk);
        while (!rdy(hp) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " in_ready"}, 64'(rdy(hp)), 64'd1);
        drive(hp, 1'b1, a);
        @(posedge clk);
        #1 drive(hp, 1'b0, $urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!vld(hp) && lat < 200);
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            drive(hp, 1'b1, $urandom);
            @(negedge clk);
            check_eq({tag, " hold data"}, 64'(dat(hp)), 64'(exp_q[0]));
            check_eq({tag, " hold flags"}, {62'd0, vld(hp), rdy(hp)}, 64'b10);
        end
        drive(hp, 1'b0, $urandom);
        set_ordy(hp, 1'b1);
        exp_v = exp_q.pop_front();
        check_eq({tag, " result"}, 64'(dat(hp)), 64'(exp_v));
        @(posedge clk);
        #1 set_ordy(hp, 1'b0);
        @(negedge clk);
        check_eq({tag, " after hs"}, {62'd0, vld(hp), rdy(hp)}, 64'b01);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] a;
        logic [32:0] want;
    } vec_t;

    vec_t sp_vecs[13] = '{
        '{32'h40800000, 33'h0_40000000},
        '{32'h42C80000, 33'h0_41200000},
        '{32'h41100000, 33'h0_40400000},
        '{32'h40000000, 33'h0_3FB504F3},
        '{32'h3F000000, 33'h0_3F3504F3},
        '{32'h41200000, 33'h0_404A62C2},
        '{32'hBF800000, 33'h1_7FC00000},
        '{32'h80000000, 33'h0_80000000},
        '{32'h7F800000, 33'h0_7F800000},
        '{32'h7FA00000, 33'h0_7FC00000},
        '{32'h00000001, 33'h0_00000000},
        '{32'hFF800000, 33'h1_7FC00000},
        '{32'h00000000, 33'h0_00000000}
    };

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset sp flags", {60'd0, sp_in_ready, sp_out_valid, sp_out_invalid, 1'b0}, 64'b1000);
        check_eq("reset sp data", 64'(sp_out_data), 64'd0);
        check_eq("reset sp state", 64'(sp_dbg), 64'(IDLE));
        check_eq("reset hp flags", {61'd0, hp_in_ready, hp_out_valid, hp_out_invalid}, 64'b100);
        check_eq("reset hp data", 64'(hp_out_data), 64'd0);
        rst = 1'b0;

        // Directed single precision.
        foreach (sp_vecs[i]) run_op(1'b0, sp_vecs[i].a, 0, 1'b1, sp_vecs[i].want, $sformatf("sp_vec%0d", i));

        // Backpressure.
        run_op(1'b0, 32'h41100000, 10, 1'b1, 33'h0_40400000, "sp_bp");

        // Reset in the middle of iteration.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h40800000);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        check_eq("mid state", 64'(sp_dbg), 64'(ITER));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort flags", {62'd0, sp_in_ready, sp_out_valid}, 64'b10);
        check_eq("abort data", 64'(sp_out_data), 64'd0);
        run_op(1'b0, 32'h40800000, 0, 1'b1, 33'h0_40000000, "sp_after_rst");

        // Random single precision: mostly positive normals, some arbitrary words.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom_range(3, 0) != 0) ? rand_normal(8, 23) : $urandom;
            run_op(1'b0, a, $urandom_range(2, 0), 1'b0, 33'd0, "sp_rand");
        end

        // Half precision.
        run_op(1'b1, 32'h4400, 0, 1'b1, 33'h0_00004000, "hp_4");
        run_op(1'b1, 32'hC400, 0, 1'b1, 33'h1_00007E00, "hp_neg");
        run_op(1'b1, 32'h8000, 0, 1'b1, 33'h0_00008000, "hp_negzero");
        for (int i = 0; i < 1000; i++) begin
            run_op(1'b1, rand_normal(5, 10), 0, 1'b0, 33'd0, "hp_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
